// File: rtl/vic_video_pkg.sv
// rtl/vic_video_pkg.sv - shared VIC-II video constants, field widths and C64 palette
package vic_video_pkg;

  localparam int R_W   = 4;
  localparam int G_W   = 4;
  localparam int B_W   = 4;
  localparam int RGB_W = R_W + G_W + B_W;
  localparam int IDX_W = 4;

  localparam int LINE_MAX_DEF = 512;

  // C64 colours reduced to 4 bits per channel, {R,G,B}
  localparam logic [RGB_W-1:0] PALETTE [16] = '{
    12'h000, 12'hFFF, 12'h833, 12'h6BB,
    12'h839, 12'h5A4, 12'h438, 12'hBC7,
    12'h852, 12'h540, 12'hB66, 12'h555,
    12'h777, 12'h9E8, 12'h76C, 12'h999
  };

  // Halve every channel independently (used for the darkened second scan)
  function automatic logic [RGB_W-1:0] dim_rgb(input logic [RGB_W-1:0] c);
    return {1'b0, c[RGB_W-1 -: R_W-1],
            1'b0, c[B_W+G_W-1 -: G_W-1],
            1'b0, c[B_W-1 -: B_W-1]};
  endfunction

endpackage

// File: rtl/vic_linebuf.sv
// rtl/vic_linebuf.sv - two-line buffer, one write port and one registered read port
module vic_linebuf #(
  parameter int AW = 9,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW:0]   raddr,
  output logic [DW-1:0] rdata
);

  // Address is {buffer select, x}; each half spans the full x range
  logic [DW-1:0] mem [2**(AW+1)];

  // Write port: pixel capture into the buffer currently being filled
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: one-cycle registered read of the buffer being replayed
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vic_scandoubler.sv
// rtl/vic_scandoubler.sv - VIC-II line doubler to 12-bit RGB; SCANLINES_EN darkens the repeat
module vic_scandoubler
  import vic_video_pkg::*;
#(
  parameter int LINE_MAX  = LINE_MAX_DEF,
  parameter int HSYNC_LEN = 60,
  parameter int AW        = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_ce,
  input  logic [IDX_W-1:0] pix_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [RGB_W-1:0] rgb_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             line_ovf
);

  localparam logic [AW:0] LMAX = (AW+1)'(LINE_MAX);
  localparam logic [AW:0] HLEN = (AW+1)'(HSYNC_LEN);

  logic             hs_prev;
  logic             line_ev;
  logic             armed;
  logic             wsel;
  logic [AW:0]      wr_x;
  logic [AW:0]      line_len;
  logic [AW:0]      rd_x;
  logic             rep;
  logic             vs_pipe;
  logic             wr_en;
  logic [AW:0]      wr_addr;
  logic [AW:0]      rd_addr;
  logic [IDX_W-1:0] rd_data;
  logic             act1;
  logic             hs1;
  logic             vs1;
  logic [RGB_W-1:0] pal_rgb;
`ifdef SCANLINES_EN
  logic             rep1;
`endif

  assign line_ev = hsync_in & ~hs_prev;
  assign rd_addr = {~wsel, rd_x[AW-1:0]};

  // Capture address: a pixel coinciding with the line event starts the new buffer at 0
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = {wsel, wr_x[AW-1:0]};
    if (line_ev) begin
      wr_en   = pix_ce;
      wr_addr = {~wsel, {AW{1'b0}}};
    end else if (armed && wr_x < LMAX) begin
      wr_en   = pix_ce;
    end
  end

  vic_linebuf #(.AW(AW), .DW(IDX_W)) u_linebuf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (pix_in),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Input side: line event bookkeeping, write pointer and overflow flag.
  // Pixels are only counted once a line event has been seen, so a partial
  // line after reset never reaches the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev  <= 1'b0;
      armed    <= 1'b0;
      wsel     <= 1'b0;
      wr_x     <= '0;
      line_len <= '0;
      vs_pipe  <= 1'b0;
      line_ovf <= 1'b0;
    end else begin
      hs_prev <= hsync_in;
      if (line_ev) begin
        armed    <= 1'b1;
        wsel     <= ~wsel;
        line_len <= wr_x;
        wr_x     <= pix_ce ? (AW+1)'(1) : '0;
        vs_pipe  <= vsync_in;
        line_ovf <= 1'b0;
      end else if (pix_ce && armed) begin
        if (wr_x < LMAX) wr_x <= wr_x + 1'b1;
        else             line_ovf <= 1'b1;
      end
    end
  end

  // Output side: replay pointer runs every clk and wraps at the captured length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_x <= '0;
      rep  <= 1'b0;
    end else if (line_ev) begin
      rd_x <= '0;
      rep  <= 1'b0;
    end else if (line_len == '0) begin
      rd_x <= '0;
    end else if (rd_x + 1'b1 == line_len) begin
      rd_x <= '0;
      rep  <= ~rep;
    end else begin
      rd_x <= rd_x + 1'b1;
    end
  end

  // Stage 1: timing signals travel alongside the registered RAM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act1 <= 1'b0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
`ifdef SCANLINES_EN
      rep1 <= 1'b0;
`endif
    end else begin
      act1 <= (line_len != '0);
      hs1  <= (line_len != '0) && (rd_x < HLEN);
      vs1  <= vs_pipe;
`ifdef SCANLINES_EN
      rep1 <= rep;
`endif
    end
  end

  // Palette lookup, darkened on the second scan when scanlines are enabled
  always_comb begin
    pal_rgb = PALETTE[rd_data];
`ifdef SCANLINES_EN
    if (rep1) pal_rgb = dim_rgb(pal_rgb);
`endif
  end

  // Stage 2: registered colour with blanking during hsync and before any line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out   <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      rgb_out   <= (hs1 || !act1) ? '0 : pal_rgb;
      hsync_out <= hs1;
      vsync_out <= vs1;
    end
  end

endmodule
